// File: rtl/uart_rx_x16.sv
// UART receiver for 8N1-style frames, oversampled by an external x16 tick.
// Start bits are qualified at mid-bit; each word is held on a valid/ack handshake.
module uart_rx_x16 #(
    parameter int P_DATA_BITS = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   tick_x16,
    input  logic                   rx,
    output logic [P_DATA_BITS-1:0] data_out,
    output logic                   data_valid,
    input  logic                   data_ack,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int BW = $clog2(P_DATA_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic                   armed_q;
    logic [3:0]             tick_cnt_q;
    logic [BW-1:0]          bit_idx_q;
    logic [P_DATA_BITS-1:0] shreg_q;
    logic [P_DATA_BITS-1:0] data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   ovr_q;
    logic                   busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            armed_q    <= 1'b0;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            if (valid_q && data_ack) begin
                valid_q <= 1'b0;
            end
            if (tick_x16) begin
                case (state_q)
                    S_IDLE: begin
                        // armed only after seeing the line high, so a held-low line cannot retrigger
                        if (rx_s_q) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q    <= S_START;
                            tick_cnt_q <= 4'd0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_START: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= 4'd0;
                            if (!rx_s_q) begin
                                state_q   <= S_DATA;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= 4'd0;
                            shreg_q    <= {rx_s_q, shreg_q[P_DATA_BITS-1:1]};
                            if (bit_idx_q == BW'(P_DATA_BITS - 1)) begin
                                state_q <= S_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end
                    end
                    S_STOP: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= 4'd0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            if (rx_s_q) begin
                                // an ack in this same cycle consumes the old word, so no overrun
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
                                ovr_q   <= valid_q && !data_ack;
                            end else begin
                                ferr_q  <= 1'b1;
                                armed_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule
